vga_timing_gen: RTL and testbench

Parametrised VGA timing and pixel-fetch controller. It is the next generation of the fixed 640x480 controller.
- Resolution, porches, sync widths, sync polarity, colour depth and pixel-RAM read latency are all parameters.
- The hs/vs/blank pipeline is aligned to the read latency, so colour and sync always leave the block on the same cycle.
- Adds frame_start and line_start strobes for the game renderer and frame-buffer swap logic.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 185 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), axis-timing helper and pixel type.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COLOR_W  = 4;
    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_RD_LAT   = 1;

    typedef struct packed {
        logic [31:0] total;
        logic [31:0] sync_start;
        logic [31:0] sync_end;
    } axis_timing_t;

    // Axis order is active -> front porch -> sync -> back porch; sync_end is inclusive.
    function automatic axis_timing_t calc_timing(input int active, input int fp,
                                                 input int sync, input int bp);
        axis_timing_t tm;
        tm.total      = 32'(active + fp + sync + bp);
        tm.sync_start = 32'(active + fp);
        tm.sync_end   = 32'(active + fp + sync - 1);
        return tm;
    endfunction

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] b;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] r;
    } pixel_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous clear to a programmable value; depth 0 is a wire.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             vga_clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_s;
            assign unused_s = vga_clk ^ clrn;
            assign dout     = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_r [DEPTH];

            // One stage per clock, all stages cleared to the inactive bundle value.
            always_ff @(posedge vga_clk or negedge clrn) begin
                if (!clrn) begin
                    for (int i = 0; i < DEPTH; i++) stage_r[i] <= RST_VAL;
                end else begin
                    stage_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and pixel-fetch controller with sync aligned to RAM read latency.
// Optional macro VGA_TEST_PATTERN_EN adds pattern_en and an 8-bar colour test pattern.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_LAT   = DEF_RD_LAT
) (
    input  logic                 vga_clk,
    input  logic                 clrn,
    input  logic [3*COLOR_W-1:0] d_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 pattern_en,
`endif
    output logic [ADDR_W-1:0]    row_addr,
    output logic [ADDR_W-1:0]    col_addr,
    output logic                 video_en,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b,
    output logic                 hs,
    output logic                 vs,
    output logic                 blank,
    output logic                 line_start,
    output logic                 frame_start
);

    localparam axis_timing_t H_T = calc_timing(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam axis_timing_t V_T = calc_timing(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int   H_TOTAL = int'(H_T.total);
    localparam int   V_TOTAL = int'(V_T.total);
    localparam int   HCW     = $clog2(H_TOTAL);
    localparam int   VCW     = $clog2(V_TOTAL);
    localparam logic HS_ON   = HS_POL[0];
    localparam logic VS_ON   = VS_POL[0];

`ifdef VGA_TEST_PATTERN_EN
    localparam int             BW         = 5 + ADDR_W;
    localparam logic [BW-1:0]  BUNDLE_RST = {~HS_ON, ~VS_ON, 3'b000, {ADDR_W{1'b0}}};
`else
    localparam int             BW         = 5;
    localparam logic [BW-1:0]  BUNDLE_RST = {~HS_ON, ~VS_ON, 3'b000};
`endif

    typedef struct packed {
        logic [COLOR_W-1:0] b;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] r;
    } pix_t;

    logic [HCW-1:0]    h_count_r;
    logic [VCW-1:0]    v_count_r;
    logic              visible_s, hs_s, vs_s, ls_s, fs_s;
    logic [ADDR_W-1:0] row_next_s, col_next_s;
    logic [BW-1:0]     bundle_a_s, bundle_a_r, bundle_d_s;
    logic              hs_d_s, vs_d_s, vis_d_s, ls_d_s, fs_d_s;
    pix_t              in_pix_s, pix_s;

    // Free-running raster counters; v advances on the h wrap edge only.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            h_count_r <= HCW'(0);
            v_count_r <= VCW'(0);
        end else if (h_count_r == HCW'(H_TOTAL - 1)) begin
            h_count_r <= HCW'(0);
            v_count_r <= (v_count_r == VCW'(V_TOTAL - 1)) ? VCW'(0) : v_count_r + VCW'(1);
        end else begin
            h_count_r <= h_count_r + HCW'(1);
        end
    end

    // Decode raster position into visibility, sync levels and strobes.
    always_comb begin
        visible_s  = (32'(h_count_r) < 32'(H_ACTIVE)) && (32'(v_count_r) < 32'(V_ACTIVE));
        hs_s       = ((32'(h_count_r) >= H_T.sync_start) && (32'(h_count_r) <= H_T.sync_end))
                     ? HS_ON : ~HS_ON;
        vs_s       = ((32'(v_count_r) >= V_T.sync_start) && (32'(v_count_r) <= V_T.sync_end))
                     ? VS_ON : ~VS_ON;
        ls_s       = visible_s && (h_count_r == HCW'(0));
        fs_s       = ls_s && (v_count_r == VCW'(0));
        row_next_s = visible_s ? ADDR_W'(v_count_r) : ADDR_W'(0);
        col_next_s = visible_s ? ADDR_W'(h_count_r) : ADDR_W'(0);
    end

`ifdef VGA_TEST_PATTERN_EN
    assign bundle_a_s = {hs_s, vs_s, visible_s, ls_s, fs_s, col_next_s};
`else
    assign bundle_a_s = {hs_s, vs_s, visible_s, ls_s, fs_s};
`endif

    // Stage A: fetch address to the RAM plus the flag bundle that tracks it.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            row_addr   <= ADDR_W'(0);
            col_addr   <= ADDR_W'(0);
            video_en   <= 1'b0;
            bundle_a_r <= BUNDLE_RST;
        end else begin
            row_addr   <= row_next_s;
            col_addr   <= col_next_s;
            video_en   <= visible_s;
            bundle_a_r <= bundle_a_s;
        end
    end

    vga_delay_line #(
        .WIDTH   (BW),
        .DEPTH   (RD_LAT),
        .RST_VAL (BUNDLE_RST)
    ) u_delay (
        .vga_clk (vga_clk),
        .clrn    (clrn),
        .din     (bundle_a_r),
        .dout    (bundle_d_s)
    );

    assign hs_d_s   = bundle_d_s[BW-1];
    assign vs_d_s   = bundle_d_s[BW-2];
    assign vis_d_s  = bundle_d_s[BW-3];
    assign ls_d_s   = bundle_d_s[BW-4];
    assign fs_d_s   = bundle_d_s[BW-5];
    assign in_pix_s = d_in;

`ifdef VGA_TEST_PATTERN_EN
    logic [ADDR_W-1:0] col_d_s;
    logic [2:0]        bar_s;
    assign col_d_s = bundle_d_s[ADDR_W-1:0];
    assign bar_s   = 3'((32'(col_d_s) * 32'd8) / 32'(H_ACTIVE));
`endif

    // Colour select: RAM pixel (or test bar) inside the visible area, black elsewhere.
    always_comb begin
        pix_s = '0;
        if (vis_d_s) begin
`ifdef VGA_TEST_PATTERN_EN
            if (pattern_en) begin
                pix_s.r = {COLOR_W{bar_s[0]}};
                pix_s.g = {COLOR_W{bar_s[1]}};
                pix_s.b = {COLOR_W{bar_s[2]}};
            end else begin
                pix_s = in_pix_s;
            end
`else
            pix_s = in_pix_s;
`endif
        end else begin
            pix_s = '0;
        end
    end

    // Output stage: every pin comes straight from a flop.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r           <= COLOR_W'(0);
            g           <= COLOR_W'(0);
            b           <= COLOR_W'(0);
            hs          <= ~HS_ON;
            vs          <= ~VS_ON;
            blank       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r           <= pix_s.r;
            g           <= pix_s.g;
            b           <= pix_s.b;
            hs          <= hs_d_s;
            vs          <= vs_d_s;
            blank       <= ~vis_d_s;
            line_start  <= ls_d_s;
            frame_start <= fs_d_s;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized self-checking bench: small raster, 3-cycle RAM model, position-based reference.
module tb_vga_timing_gen;

    localparam int HA = 20, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int HS_POL = 1, VS_POL = 0;
    localparam int CW = 4, AW = 6, LAT = 3;
    localparam int L = LAT + 2;

    logic          vga_clk = 1'b0;
    logic          clrn    = 1'b0;
    logic [11:0]   d_in    = 12'hFFF;
`ifdef VGA_TEST_PATTERN_EN
    logic          pattern_en = 1'b0;
    bit            pat_at_edge;
`endif
    logic [AW-1:0] row_addr, col_addr;
    logic          video_en, hs, vs, blank, line_start, frame_start;
    logic [CW-1:0] r, g, b;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .COLOR_W(CW), .ADDR_W(AW), .RD_LAT(LAT)
    ) dut (
        .vga_clk(vga_clk), .clrn(clrn), .d_in(d_in),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_en(pattern_en),
`endif
        .row_addr(row_addr), .col_addr(col_addr), .video_en(video_en),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .blank(blank),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 vga_clk = ~vga_clk;

    int          errors = 0, checks = 0;
    longint      t = 0;
    logic [11:0] mem [VA][HA];
    logic [2*AW:0] pipe [LAT+1];
    bit          formula_phase = 1'b1;
    bit          rst_at_edge;
    int          hs_line_cnt, hs_frame_cnt, vs_frame_cnt;
    longint      last_fs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    function automatic logic [11:0] exp_pixel(input int v, input int h);
        logic [11:0] px;
        px = mem[v][h];
`ifdef VGA_TEST_PATTERN_EN
        if (pat_at_edge) begin
            int bar;
            bar = (h * 8) / HA;
            px = {((bar & 4) != 0) ? 4'hF : 4'h0, ((bar & 2) != 0) ? 4'hF : 4'h0,
                  ((bar & 1) != 0) ? 4'hF : 4'h0};
        end
`endif
        return px;
    endfunction

    task automatic check_reset_pins(input string tag);
        chk({tag, "_row"}, 32'(row_addr), 32'd0);
        chk({tag, "_col"}, 32'(col_addr), 32'd0);
        chk({tag, "_ve"}, 32'(video_en), 32'd0);
        chk({tag, "_rgb"}, 32'({b, g, r}), 32'd0);
        chk({tag, "_hs"}, 32'(hs), 32'd0);
        chk({tag, "_vs"}, 32'(vs), 32'd1);
        chk({tag, "_blank"}, 32'(blank), 32'd1);
        chk({tag, "_ls"}, 32'(line_start), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    task automatic check_cycle();
        int p, q, h, v;
        bit vis, ehs, evs;
        if (t == 0) begin
            check_reset_pins("rst");
            hs_line_cnt = 0; hs_frame_cnt = 0; vs_frame_cnt = 0; last_fs = 0;
            return;
        end
        p = int'((t - 1) % FRAME);
        h = p % HT; v = p / HT;
        vis = (h < HA) && (v < VA);
        chk("row_addr", 32'(row_addr), vis ? 32'(v) : 32'd0);
        chk("col_addr", 32'(col_addr), vis ? 32'(h) : 32'd0);
        chk("video_en", 32'(video_en), 32'(vis));
        if (t == L - 1) chk("fs_early", 32'(frame_start), 32'd0);
        if (t < L) begin
            chk("pre_out_blank", 32'(blank), 32'd1);
            chk("pre_out_rgb", 32'({b, g, r}), 32'd0);
            return;
        end
        q = int'((t - L) % FRAME);
        h = q % HT; v = q / HT;
        vis = (h < HA) && (v < VA);
        ehs = (h >= HA + HFP && h < HA + HFP + HSW) ? HS_POL[0] : !HS_POL[0];
        evs = (v >= VA + VFP && v < VA + VFP + VSW) ? VS_POL[0] : !VS_POL[0];
        chk("hs", 32'(hs), 32'(ehs));
        chk("vs", 32'(vs), 32'(evs));
        chk("blank", 32'(blank), 32'(!vis));
        chk("line_start", 32'(line_start), 32'(vis && h == 0));
        chk("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
        chk("rgb", 32'({b, g, r}), vis ? 32'(exp_pixel(v, h)) : 32'd0);
        if (blank === 1'b1) chk("blank_rgb_zero", 32'({b, g, r}), 32'd0);
        if (t == L) chk("fs_after_release", 32'(frame_start), 32'd1);
`ifdef VGA_TEST_PATTERN_EN
        if (formula_phase && !pat_at_edge && v == 5 && h == 17)
            chk("pix_5_17", 32'({b, g, r}), 32'h511);
        if (pat_at_edge && vis && h == 0)  chk("bar0_black", 32'({b, g, r}), 32'h000);
        if (pat_at_edge && vis && h == 3)  chk("bar1_red", 32'({b, g, r}), 32'h00F);
        if (pat_at_edge && vis && h == 19) chk("bar7_white", 32'({b, g, r}), 32'hFFF);
`else
        if (formula_phase && v == 5 && h == 17) chk("pix_5_17", 32'({b, g, r}), 32'h511);
`endif
        // Window counters measured purely from the pins.
        if (h == 0) hs_line_cnt = 0;
        if (q == 0) begin hs_frame_cnt = 0; vs_frame_cnt = 0; end
        if (hs == 1'b1) begin hs_line_cnt++; hs_frame_cnt++; end
        if (vs == 1'b0) vs_frame_cnt++;
        if (h == HT - 1) chk("hs_per_line", 32'(hs_line_cnt), 32'd3);
        if (q == FRAME - 1) begin
            chk("hs_per_frame", 32'(hs_frame_cnt), 32'd30);
            chk("vs_per_frame", 32'(vs_frame_cnt), 32'd56);
        end
        if (frame_start === 1'b1) begin
            if (last_fs != 0) chk("fs_period", 32'(t - last_fs), 32'd280);
            last_fs = t;
        end
    endtask

    task automatic drive_ram();
        for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = {video_en, row_addr, col_addr};
        if (pipe[LAT][2*AW] && pipe[LAT][2*AW-1:AW] < VA && pipe[LAT][AW-1:0] < HA)
            d_in = mem[pipe[LAT][2*AW-1:AW]][pipe[LAT][AW-1:0]];
        else
            d_in = 12'hFFF;
    endtask

    always @(posedge vga_clk) begin
        rst_at_edge = !clrn;
`ifdef VGA_TEST_PATTERN_EN
        pat_at_edge = pattern_en;
`endif
        #1;
        if (rst_at_edge) t = 0;
        else t = t + 1;
        check_cycle();
        drive_ram();
    end

    task automatic reset_at(input int target);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 2 * FRAME && !hit; k++) begin
            @(posedge vga_clk); #2;
            if (t > 0 && int'((t - 1) % FRAME) == target) hit = 1'b1;
        end
        chk("reset_target_reached", 32'(hit), 32'd1);
        chk("pre_rst_ve", 32'(video_en), 32'd1);
        #1 clrn = 1'b0;
        #1 check_reset_pins("async_rst");
        for (int vv = 0; vv < VA; vv++)
            for (int hh = 0; hh < HA; hh++) mem[vv][hh] = 12'($urandom);
        formula_phase = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge vga_clk);
        #3 clrn = 1'b1;
    endtask

    initial begin
        for (int vv = 0; vv < VA; vv++)
            for (int hh = 0; hh < HA; hh++) mem[vv][hh] = {4'(vv), 8'(hh)};
        for (int i = 0; i <= LAT; i++) pipe[i] = '0;
        repeat (3) @(posedge vga_clk);
        #3 clrn = 1'b1;
        @(posedge vga_clk); #2;
        chk("rel_video_en", 32'(video_en), 32'd1);
        chk("rel_row", 32'(row_addr), 32'd0);
        chk("rel_col", 32'(col_addr), 32'd0);
        repeat (2 * FRAME + 40) @(posedge vga_clk);
        reset_at(4 * HT + $urandom_range(0, HA - 1));
        repeat (FRAME + 30) @(posedge vga_clk);
`ifdef VGA_TEST_PATTERN_EN
        #3 pattern_en = 1'b1;
        repeat (FRAME) @(posedge vga_clk);
`endif
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(20, 120)) @(posedge vga_clk);
`ifdef VGA_TEST_PATTERN_EN
            #3 pattern_en = 1'($urandom_range(0, 1));
`endif
        end
        reset_at($urandom_range(0, VA - 1) * HT + $urandom_range(0, HA - 1));
        repeat (FRAME + 50) @(posedge vga_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
